// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands one round key per cycle into an 11-entry store.
// Serves encrypt keys or equivalent-inverse-cipher keys through a registered port.
package aes_pkg;
  typedef enum logic [1:0] {
    INVALID = 2'b00,
    ENCRYPT = 2'b01,
    DECRYPT = 2'b10
  } job_t;
endpackage

module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  output logic             key_busy,
  output logic             key_ready,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  input  job_t             rd_type,
  output logic [KEY_W-1:0] rd_key,
  output job_t             rd_type_out
);

  localparam logic [3:0] IDX_NR = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [127:0] next_key(
    input logic [127:0] p,
    input logic [7:0]   rc
  );
    logic [31:0] rot, t, w0, w1, w2, w3;
    rot = {p[23:0], p[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]),
           sbox(rot[15:8]), sbox(rot[7:0])};
    t   = t ^ {rc, 24'h0};
    w0  = p[127:96] ^ t;
    w1  = p[95:64] ^ w0;
    w2  = p[63:32] ^ w1;
    w3  = p[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // 9/b/d/e multiples built from an xtime chain per byte
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = c[31-8*r -: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      o[31-8*r -: 8] = me[r] ^ mb[(r+1)%4]
                     ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    return {inv_col(k[127:96]), inv_col(k[95:64]),
            inv_col(k[63:32]), inv_col(k[31:0])};
  endfunction

  state_t           state, state_nx;
  logic [3:0]       cnt;
  logic [3:0]       prev_idx;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] rk [NR+1];
  logic [KEY_W-1:0] rk_nx;
  logic [KEY_W-1:0] rd_val;
  logic [3:0]       idx;
  logic             rd_ok;

  always_comb begin
    state_nx  = state;
    key_busy  = 1'b0;
    key_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_load) state_nx = EXPAND;
      end
      EXPAND: begin
        key_busy = 1'b1;
        if (cnt == IDX_NR) state_nx = READY;
      end
      READY: begin
        key_ready = 1'b1;
        if (key_load) state_nx = EXPAND;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign rk_nx    = next_key(rk[prev_idx], rcon);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rcon  <= 8'h01;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        EXPAND: begin
          rk[cnt] <= rk_nx;
          cnt     <= cnt + 4'd1;
          rcon    <= xt(rcon);
        end
        default: begin
          if (key_load) begin
            rk[0] <= key_in;
            cnt   <= 4'd1;
            rcon  <= 8'h01;
          end
        end
      endcase
    end
  end

  assign rd_ok = rd_en && key_ready && (rd_idx <= IDX_NR)
              && (rd_type != INVALID);

  always_comb begin
    rd_val = '0;
    idx    = rd_idx;
    if (rd_type == DECRYPT) idx = IDX_NR - rd_idx;
    unique case (1'b1)
      !rd_ok: rd_val = '0;
      rd_ok && rd_type == ENCRYPT: rd_val = rk[rd_idx];
      rd_ok && rd_type == DECRYPT
        && (rd_idx == 4'd0 || rd_idx == IDX_NR):
        rd_val = rk[idx];
      rd_ok && rd_type == DECRYPT
        && rd_idx != 4'd0 && rd_idx != IDX_NR:
        rd_val = inv_mix(rk[idx]);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_key      <= '0;
      rd_type_out <= INVALID;
    end else begin
      rd_key      <= rd_val;
      rd_type_out <= rd_en ? rd_type : INVALID;
    end
  end

endmodule
